// File: rtl/timer_pkg.sv
// Shared encodings for the countdown timer.
// State and cursor enums, field limits.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_EDIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CUR_SEC = 2'd0,
    CUR_MIN = 2'd1,
    CUR_HR  = 2'd2
  } cursor_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/timer_field_counter.sv
// One wrapping time field (0..MAX) with load, up/down and borrow chain.
// Ports: i_load/i_val load; i_up/i_down edit; i_bin borrow in; o_bout borrow out.
module timer_field_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_bin,
  output logic [W-1:0] o_q,
  output logic         o_bout
);
  import timer_pkg::*;

  localparam logic [W-1:0] L_MAX = W'(MAX);

  logic [W-1:0] r_q;
  logic         w_zero;

  assign w_zero = (r_q == '0);
  assign o_q    = r_q;
  // Borrow only propagates from the chain, never from edits.
  assign o_bout = i_bin & w_zero;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_val;
    end else if (i_up) begin
      r_q <= (r_q == L_MAX) ? '0 : r_q + 1'b1;
    end else if (i_down | i_bin) begin
      r_q <= w_zero ? L_MAX : r_q - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_n.sv
// HH:MM:SS countdown timer: edit preset, run on ms tick, pause, alarm.
// Inputs: i_clk, i_rstn, i_ms_pulse, buttons. Outputs: fields, cursor,
// state, o_expired, o_alarm. Macro AUTO_RELOAD_EN: reload on expiry.
module countdown_timer_n #(
  parameter int MS_PER_SEC = 1000,
  parameter int HR_MAX     = 23,
  parameter int ALARM_MS   = 5000,
  localparam int MS_W = $clog2(MS_PER_SEC),
  localparam int HR_W = $clog2(HR_MAX + 1)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_ms_pulse,
  input  logic            i_up,
  input  logic            i_down,
  input  logic            i_left,
  input  logic            i_right,
  input  logic            i_set,
  output logic [MS_W-1:0] o_ms,
  output logic [5:0]      o_sec,
  output logic [5:0]      o_min,
  output logic [HR_W-1:0] o_hr,
  output logic [1:0]      o_cursor,
  output logic [1:0]      o_state,
  output logic            o_expired,
  output logic            o_alarm
);
  import timer_pkg::*;

  state_e          r_state, w_nstate;
  cursor_e         r_cursor, w_ncur;
  logic [5:0]      r_pre_sec, r_pre_min;
  logic [HR_W-1:0] r_pre_hr;
  logic            r_expired;

  logic [MS_W-1:0] w_ms;
  logic [5:0]      w_sec, w_min;
  logic [HR_W-1:0] w_hr;
  logic w_ms_b, w_sec_b, w_min_b, w_hr_b;
  logic w_tick, w_last, w_allzero, w_btn;
  logic w_ld_ms, w_ld_fld, w_cap, w_eup, w_edn;

  assign w_tick    = (r_state == ST_RUN) & i_ms_pulse;
  assign w_allzero = (w_hr == '0) & (w_min == '0) & (w_sec == '0);
  // Value is exactly one tick from zero.
  assign w_last    = w_tick & w_allzero & (w_ms == MS_W'(1));
  assign w_btn     = i_up | i_down | i_left | i_right | i_set;

  timer_field_counter #(.MAX(MS_PER_SEC-1), .W(MS_W)) u_ms (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_load(w_ld_ms), .i_val('0),
    .i_up(1'b0), .i_down(1'b0), .i_bin(w_tick),
    .o_q(w_ms), .o_bout(w_ms_b)
  );

  timer_field_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_load(w_ld_fld), .i_val(r_pre_sec),
    .i_up(w_eup & (r_cursor == CUR_SEC)),
    .i_down(w_edn & (r_cursor == CUR_SEC)),
    .i_bin(w_ms_b),
    .o_q(w_sec), .o_bout(w_sec_b)
  );

  timer_field_counter #(.MAX(MIN_MAX), .W(6)) u_min (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_load(w_ld_fld), .i_val(r_pre_min),
    .i_up(w_eup & (r_cursor == CUR_MIN)),
    .i_down(w_edn & (r_cursor == CUR_MIN)),
    .i_bin(w_sec_b),
    .o_q(w_min), .o_bout(w_min_b)
  );

  timer_field_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_load(w_ld_fld), .i_val(r_pre_hr),
    .i_up(w_eup & (r_cursor == CUR_HR)),
    .i_down(w_edn & (r_cursor == CUR_HR)),
    .i_bin(w_min_b),
    .o_q(w_hr), .o_bout(w_hr_b)
  );

`ifndef AUTO_RELOAD_EN
  localparam int AW = (ALARM_MS > 1) ? $clog2(ALARM_MS) : 1;
  localparam logic [AW-1:0] AL_LAST =
    AW'((ALARM_MS > 0) ? ALARM_MS - 1 : 0);

  logic [AW-1:0] r_al_cnt;
  logic          r_alarm;
  logic          w_al_done;

  assign w_al_done = (ALARM_MS > 0) & i_ms_pulse &
                     (r_al_cnt == AL_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_al_cnt <= '0;
      r_alarm  <= 1'b0;
    end else begin
      r_alarm <= (w_nstate == ST_ALARM);
      if (r_state != ST_ALARM) r_al_cnt <= '0;
      else if (i_ms_pulse)     r_al_cnt <= r_al_cnt + 1'b1;
    end
  end

  assign o_alarm = r_alarm;
`else
  assign o_alarm = 1'b0;
`endif

  always_comb begin
    w_nstate = r_state;
    w_ncur   = r_cursor;
    w_ld_ms  = 1'b0;
    w_ld_fld = 1'b0;
    w_cap    = 1'b0;
    w_eup    = 1'b0;
    w_edn    = 1'b0;
    unique case (r_state)
      ST_EDIT: begin
        if (i_set) begin
          if (!w_allzero) begin
            w_cap    = 1'b1;
            w_ld_ms  = 1'b1;
            w_nstate = ST_RUN;
          end
        end else if (i_up) begin
          w_eup = 1'b1;
        end else if (i_down) begin
          w_edn = 1'b1;
        end else if (i_left) begin
          unique case (r_cursor)
            CUR_SEC: w_ncur = CUR_MIN;
            CUR_MIN: w_ncur = CUR_HR;
            default: w_ncur = CUR_SEC;
          endcase
        end else if (i_right) begin
          unique case (r_cursor)
            CUR_SEC: w_ncur = CUR_HR;
            CUR_HR:  w_ncur = CUR_MIN;
            default: w_ncur = CUR_SEC;
          endcase
        end
      end
      ST_RUN: begin
        // Hour underflow cannot occur; treated as expiry if it did.
        if (w_last | w_hr_b) begin
`ifdef AUTO_RELOAD_EN
          w_ld_fld = 1'b1;
          w_ld_ms  = 1'b1;
`else
          w_nstate = ST_ALARM;
`endif
        end else if (i_set) begin
          w_nstate = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (i_set) begin
          w_nstate = ST_RUN;
        end else if (i_down) begin
          w_nstate = ST_EDIT;
          w_ld_ms  = 1'b1;
        end
      end
      default: begin
`ifndef AUTO_RELOAD_EN
        if (w_btn | w_al_done) begin
`endif
          w_nstate = ST_EDIT;
          w_ld_fld = 1'b1;
          w_ld_ms  = 1'b1;
`ifndef AUTO_RELOAD_EN
        end
`endif
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= ST_EDIT;
      r_cursor  <= CUR_SEC;
      r_pre_sec <= '0;
      r_pre_min <= '0;
      r_pre_hr  <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cursor  <= w_ncur;
      r_expired <= w_last;
      if (w_cap) begin
        r_pre_sec <= w_sec;
        r_pre_min <= w_min;
        r_pre_hr  <= w_hr;
      end
    end
  end

  assign o_ms      = w_ms;
  assign o_sec     = w_sec;
  assign o_min     = w_min;
  assign o_hr      = w_hr;
  assign o_cursor  = r_cursor;
  assign o_state   = r_state;
  assign o_expired = r_expired;

endmodule

// File: tb/tb_countdown_timer_n.sv
// Directed bench for countdown_timer_n, MS_PER_SEC=4, ALARM_MS=2.
// Expected snapshots are queued and popped against DUT outputs.
module tb_countdown_timer_n;

  localparam int MSPS = 4;
  localparam int MS_W = 2;
  localparam int HR_W = 5;

  localparam logic [5:0] B_SET = 6'b100000;
  localparam logic [5:0] B_UP  = 6'b010000;
  localparam logic [5:0] B_DN  = 6'b001000;
  localparam logic [5:0] B_LF  = 6'b000100;
  localparam logic [5:0] B_RT  = 6'b000010;
  localparam logic [5:0] B_MS  = 6'b000001;
  localparam logic [5:0] B_NO  = 6'b000000;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  logic i_ms_pulse = 1'b0;
  logic i_up = 1'b0, i_down = 1'b0;
  logic i_left = 1'b0, i_right = 1'b0;
  logic i_set = 1'b0;
  logic [MS_W-1:0] o_ms;
  logic [5:0] o_sec, o_min;
  logic [HR_W-1:0] o_hr;
  logic [1:0] o_cursor, o_state;
  logic o_expired, o_alarm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;
  exp_t sb[$];

  countdown_timer_n #(
    .MS_PER_SEC(MSPS), .HR_MAX(23), .ALARM_MS(2)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_ms_pulse(i_ms_pulse),
    .i_up(i_up), .i_down(i_down),
    .i_left(i_left), .i_right(i_right),
    .i_set(i_set),
    .o_ms(o_ms), .o_sec(o_sec), .o_min(o_min),
    .o_hr(o_hr), .o_cursor(o_cursor),
    .o_state(o_state), .o_expired(o_expired),
    .o_alarm(o_alarm)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [24:0] pk(
    int st, int cur, int hr, int mn, int sc,
    int ms, int ex, int al);
    pk = {2'(st), 2'(cur), 5'(hr), 6'(mn),
          6'(sc), 2'(ms), 1'(ex), 1'(al)};
  endfunction

  function automatic logic [24:0] obs();
    obs = {o_state, o_cursor, o_hr, o_min,
           o_sec, o_ms, o_expired, o_alarm};
  endfunction

  task automatic expect_now(input string tag,
                            input logic [24:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [24:0] o;
    e = sb.pop_front();
    o = obs();
    checks++;
    assert (o === e.v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             e.tag, o, e.v);
    end
  endtask

  task automatic chk(input string tag,
                     input logic [24:0] v);
    expect_now(tag, v);
    check();
  endtask

  task automatic step(input logic [5:0] b);
    {i_set, i_up, i_down, i_left, i_right, i_ms_pulse} = b;
    @(posedge i_clk);
    #1;
    {i_set, i_up, i_down, i_left, i_right, i_ms_pulse} = '0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(B_MS);
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

`ifdef AUTO_RELOAD_EN
  int n_exp;
  int n_al;
`endif

  initial begin
    do_reset();
    chk("reset", pk(0, 0, 0, 0, 0, 0, 0, 0));

`ifndef AUTO_RELOAD_EN
    repeat (3) step(B_UP);
    chk("edit_sec3", pk(0, 0, 0, 0, 3, 0, 0, 0));
    step(B_SET);
    chk("run_start", pk(1, 0, 0, 0, 3, 0, 0, 0));
    ticks(11);
    chk("tick11", pk(1, 0, 0, 0, 0, 1, 0, 0));
    ticks(1);
    chk("expire12", pk(3, 0, 0, 0, 0, 0, 1, 1));
    step(B_NO);
    chk("alarm_hold", pk(3, 0, 0, 0, 0, 0, 0, 1));
    ticks(1);
    chk("alarm_t1", pk(3, 0, 0, 0, 0, 0, 0, 1));
    ticks(1);
    chk("alarm_exit", pk(0, 0, 0, 0, 3, 0, 0, 0));

    repeat (4) step(B_DN);
    chk("sec_wrap_dn", pk(0, 0, 0, 0, 59, 0, 0, 0));
    repeat (2) step(B_LF);
    step(B_DN);
    chk("hr_wrap_dn", pk(0, 2, 23, 0, 59, 0, 0, 0));
    step(B_UP);
    chk("hr_wrap_up", pk(0, 2, 0, 0, 59, 0, 0, 0));
    step(B_LF);
    chk("cur_left_wrap", pk(0, 0, 0, 0, 59, 0, 0, 0));
    step(B_RT);
    chk("cur_right_wrap", pk(0, 2, 0, 0, 59, 0, 0, 0));
    step(B_UP | B_DN | B_LF);
    chk("edit_prio", pk(0, 2, 1, 0, 59, 0, 0, 0));
    do_reset();
    chk("reset2", pk(0, 0, 0, 0, 0, 0, 0, 0));
    step(B_SET);
    chk("set_zero", pk(0, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) step(B_LF);
    step(B_UP);
    step(B_SET);
    chk("run_1h", pk(1, 2, 1, 0, 0, 0, 0, 0));
    step(B_UP | B_LF | B_MS);
    chk("borrow", pk(1, 2, 0, 59, 59, 3, 0, 0));
    #2 i_rstn = 1'b0;
    #1;
    chk("async_rst", pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge i_clk);
    #1 i_rstn = 1'b1;

    repeat (2) step(B_UP);
    step(B_SET);
    ticks(3);
    chk("run_3t", pk(1, 0, 0, 0, 1, 1, 0, 0));
    step(B_SET);
    chk("pause", pk(2, 0, 0, 0, 1, 1, 0, 0));
    ticks(10);
    chk("pause_hold", pk(2, 0, 0, 0, 1, 1, 0, 0));
    step(B_SET);
    chk("resume", pk(1, 0, 0, 0, 1, 1, 0, 0));
    ticks(4);
    chk("resume_4t", pk(1, 0, 0, 0, 0, 1, 0, 0));
    ticks(1);
    chk("resume_exp", pk(3, 0, 0, 0, 0, 0, 1, 1));
    step(B_UP);
    chk("alarm_btn", pk(0, 0, 0, 0, 2, 0, 0, 0));

    step(B_SET);
    ticks(7);
    step(B_SET | B_MS);
    chk("set_on_zero", pk(3, 0, 0, 0, 0, 0, 1, 1));
    step(B_LF | B_MS);
    chk("btn_tick_exit", pk(0, 0, 0, 0, 2, 0, 0, 0));

    step(B_SET);
    ticks(1);
    chk("run_1t", pk(1, 0, 0, 0, 1, 3, 0, 0));
    step(B_SET);
    step(B_DN);
    chk("pause_down", pk(0, 0, 0, 0, 1, 0, 0, 0));
`else
    n_exp = 0;
    n_al  = 0;
    step(B_UP);
    step(B_SET);
    chk("ar_start", pk(1, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      step(B_MS);
      if (o_expired) n_exp++;
      if (o_alarm) n_al++;
    end
    chk("ar_end", pk(1, 0, 0, 0, 1, 0, 1, 0));
    expect_now("ar_pulses", 25'(2));
    e_cnt_check();
    expect_now("ar_alarm", 25'(0));
    e_al_check();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

`ifdef AUTO_RELOAD_EN
  task automatic e_cnt_check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (25'(n_exp) === e.v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             e.tag, n_exp, e.v);
    end
  endtask

  task automatic e_al_check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (25'(n_al) === e.v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             e.tag, n_al, e.v);
    end
  endtask
`endif

endmodule
